// File: rtl/usr_shift_burst.sv
// ============================================================================
//  Module   : usr_shift_burst
//  Brief    : WIDTH-bit universal shift register; one start runs an n-step
//             shift burst with busy/done handshake. Optional: USR_ROTATE_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module usr_shift_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic             en,
    input  logic             ser_l,
    input  logic             ser_r,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] p,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_MODE_HOLD = 2'b01;
    localparam logic [1:0] c_MODE_LOAD = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;      // 0 = left (toward MSB), 1 = right
    logic             w_fill_l;
    logic             w_fill_r;

`ifdef USR_ROTATE_EN
    logic             r_rot;
    assign w_fill_l = r_rot ? p[WIDTH-1] : ser_l;
    assign w_fill_r = r_rot ? p[0]       : ser_r;
`else
    assign w_fill_l = ser_l;
    assign w_fill_r = ser_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            p       <= '0;
            so      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef USR_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (s == c_MODE_LOAD) begin
                            p    <= a;
                            done <= 1'b1;
                        end else if (s == c_MODE_HOLD || n == '0) begin
                            done <= 1'b1;
                        end else begin
                            // Burst armed here; the first shift lands on the next edge.
                            r_dir   <= s[1];
                            r_cnt   <= n;
                            busy    <= 1'b1;
                            r_state <= ST_SHIFT;
`ifdef USR_ROTATE_EN
                            r_rot   <= rot;
`endif
                        end
                    end
                end
                ST_SHIFT: begin
                    if (en) begin
                        if (r_dir) begin
                            p  <= {w_fill_r, p[WIDTH-1:1]};
                            so <= p[0];
                        end else begin
                            p  <= {p[WIDTH-2:0], w_fill_l};
                            so <= p[WIDTH-1];
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usr_shift_burst.sv
// ============================================================================
//  Module   : tb_usr_shift_burst
//  Brief    : Self-checking bench for usr_shift_burst (WIDTH=8, CNT_W=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_usr_shift_burst;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] s     = 2'b01;
    logic [7:0] a     = 8'h00;
    logic       start = 1'b0;
    logic [3:0] n     = 4'd0;
    logic       en    = 1'b0;
    logic       ser_l = 1'b0;
    logic       ser_r = 1'b0;
    logic       rot   = 1'b0;
    logic [7:0] p;
    logic       so;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    usr_shift_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .a     (a),
        .start (start),
        .n     (n),
        .en    (en),
        .ser_l (ser_l),
        .ser_r (ser_r),
`ifdef USR_ROTATE_EN
        .rot   (rot),
`endif
        .p     (p),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: a register plus "shifts still owed"; busy is simply rem != 0.
    typedef struct packed {
        logic [7:0] p;
        logic       so;
        logic       done;
        logic       dir;
        logic       rot;
        logic [7:0] rem;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t step(input mdl_t c, input logic st, input logic [1:0] md,
                                  input logic [3:0] cnt, input logic [7:0] d, input logic e,
                                  input logic sl, input logic sr, input logic rt);
        mdl_t x;
        int   fill;
        x      = c;
        x.done = 1'b0;
        if (c.rem == 0) begin
            if (st) begin
                if (md == 2'b11) begin
                    x.p    = d;
                    x.done = 1'b1;
                end else if (md == 2'b01 || cnt == 0) begin
                    x.done = 1'b1;
                end else begin
                    x.rem = 8'(cnt);
                    x.dir = (md == 2'b10);
                    x.rot = rt;
                end
            end
        end else if (e) begin
            if (!c.dir) begin
                fill = c.rot ? int'(c.p) / 128 : int'(sl);
                x.so = (int'(c.p) / 128) == 1;
                x.p  = 8'((int'(c.p) * 2 + fill) % 256);
            end else begin
                fill = c.rot ? int'(c.p) % 2 : int'(sr);
                x.so = (int'(c.p) % 2) == 1;
                x.p  = 8'(int'(c.p) / 2 + fill * 128);
            end
            x.rem  = c.rem - 8'd1;
            x.done = (x.rem == 0);
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, start, s, n, a, en, ser_l, ser_r, rot);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_p",    32'(p),    32'(m.p));
        check("cyc_so",   32'(so),   32'(m.so));
        check("cyc_busy", 32'(busy), 32'(m.rem != 0));
        check("cyc_done", 32'(done), 32'(m.done));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_lp [3] = '{8'hB5, 8'h6B, 8'hD7};
    logic       exp_ls [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        int busy_cycles;

        // Asynchronous reset with no clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_p",    32'(p),    32'h0);
        check("rst_so",   32'(so),   32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Parallel load
        start = 1'b1; s = 2'b11; a = 8'b11011010;
        tick();
        check("load_p",    32'(p),    32'hDA);
        check("load_done", 32'(done), 32'h1);
        check("load_busy", 32'(busy), 32'h0);
        start = 1'b0;
        tick();
        check("load_done_clr", 32'(done), 32'h0);

        // Left burst n=3, fill 1
        start = 1'b1; s = 2'b00; n = 4'd3; ser_l = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        check("l_arm_busy", 32'(busy), 32'h1);
        check("l_arm_p",    32'(p),    32'hDA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("l_p",    32'(p),    32'(exp_lp[i]));
            check("l_so",   32'(so),   32'(exp_ls[i]));
            check("l_busy", 32'(busy), 32'(i < 2));
        end
        check("l_done", 32'(done), 32'h1);

        // Right burst n=2 with a two-cycle stall, issued back-to-back
        start = 1'b1; s = 2'b10; n = 4'd2; ser_r = 1'b0; en = 1'b1;
        busy_cycles = 0;
        tick(); start = 1'b0; busy_cycles += int'(busy);
        tick(); busy_cycles += int'(busy);
        check("r1_p",  32'(p),  32'h6B);
        check("r1_so", 32'(so), 32'h1);
        en = 1'b0;
        tick(); busy_cycles += int'(busy);
        tick(); busy_cycles += int'(busy);
        check("r_stall_p", 32'(p), 32'h6B);
        en = 1'b1;
        tick(); busy_cycles += int'(busy);
        check("r2_p",    32'(p),    32'h35);
        check("r2_so",   32'(so),   32'h1);
        check("r2_done", 32'(done), 32'h1);
        check("r_busy_cycles", 32'(busy_cycles), 32'd4);

        // Zero count and hold
        start = 1'b1; s = 2'b00; n = 4'd0;
        tick();
        check("n0_p",    32'(p),    32'h35);
        check("n0_done", 32'(done), 32'h1);
        check("n0_busy", 32'(busy), 32'h0);
        s = 2'b01; n = 4'd5;
        tick();
        check("hold_p",    32'(p),    32'h35);
        check("hold_done", 32'(done), 32'h1);

        // Load attempt while busy is ignored
        s = 2'b00; n = 4'd2; ser_l = 1'b0; en = 1'b1;
        tick();
        s = 2'b11; a = 8'hFF;
        tick();
        check("ign_p1", 32'(p), 32'h6A);
        tick();
        check("ign_p2",   32'(p),    32'hD4);
        check("ign_done", 32'(done), 32'h1);
        start = 1'b0;
        tick();

        // Reset mid-burst
        start = 1'b1; s = 2'b10; n = 4'd9;
        tick(); start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_p",    32'(p),    32'h0);
        check("mrst_so",   32'(so),   32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_done", 32'(done), 32'h0);
        #1 rst_n = 1'b1;
        tick();

`ifdef USR_ROTATE_EN
        start = 1'b1; s = 2'b11; a = 8'hF0;
        tick();
        s = 2'b00; n = 4'd4; rot = 1'b1; ser_l = 1'b0; en = 1'b1;
        tick(); start = 1'b0; rot = 1'b0;
        repeat (4) tick();
        check("rot_p",  32'(p),  32'h0F);
        check("rot_so", 32'(so), 32'h1);
        tick();
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            s     = 2'($urandom);
            n     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            a     = 8'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            ser_l = 1'($urandom);
            ser_r = 1'($urandom);
`ifdef USR_ROTATE_EN
            rot   = 1'($urandom);
`endif
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
